// File: rtl/cmp_share_arb.sv
// cmp_share_arb: round-robin scheduler sharing one registered eq/lt/gt comparator among NREQ requesters.
// Build option: define CMP_SIGNED_EN to compare operands as two's-complement signed values.
module cmp_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] a_in_i,
    input  logic [NREQ*WIDTH-1:0] b_in_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       ack_o,
    output logic                  res_eq_o,
    output logic                  res_lt_o,
    output logic                  res_gt_o,
    output logic                  busy_o
);
    localparam int IW  = $clog2(NREQ);
    localparam int IW1 = IW + 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RESULT} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    win_q, win_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;

    logic [NREQ-1:0]  cand_c;
    logic             found_c;
    logic [IW-1:0]    pick_c;
    logic [IW1-1:0]   idx_c;
    logic [WIDTH-1:0] a_sel_c;
    logic [WIDTH-1:0] b_sel_c;
    logic             cmp_lt_c;
    logic             cmp_gt_c;

    // The requester acked this cycle may still hold req; it must not win back-to-back.
    assign cand_c = (state_q == ST_RESULT) ? (req_i & ~ack_q) : req_i;

    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx_c   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_c = {1'b0, ptr_q} + IW1'(k);
            if (idx_c >= IW1'(NREQ)) begin
                idx_c = idx_c - IW1'(NREQ);
            end
            if (!found_c && cand_c[idx_c[IW-1:0]]) begin
                found_c = 1'b1;
                pick_c  = idx_c[IW-1:0];
            end
        end
    end

    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_c == IW'(k)) begin
                a_sel_c = a_in_i[k*WIDTH +: WIDTH];
                b_sel_c = b_in_i[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef CMP_SIGNED_EN
    assign cmp_lt_c = $signed(a_q) < $signed(b_q);
    assign cmp_gt_c = $signed(a_q) > $signed(b_q);
`else
    assign cmp_lt_c = a_q < b_q;
    assign cmp_gt_c = a_q > b_q;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = '0;
        ack_d   = '0;
        a_d     = a_q;
        b_d     = b_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        case (state_q)
            ST_IDLE, ST_RESULT: begin
                if (found_c) begin
                    state_d = ST_GRANT;
                    win_d   = pick_c;
                    gnt_d   = ONE_HOT0 << pick_c;
                    a_d     = a_sel_c;
                    b_d     = b_sel_c;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_d = ST_RESULT;
                ack_d   = ONE_HOT0 << win_q;
                eq_d    = (a_q == b_q);
                lt_d    = cmp_lt_c;
                gt_d    = cmp_gt_c;
                ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign ack_o    = ack_q;
    assign res_eq_o = eq_q;
    assign res_lt_o = lt_q;
    assign res_gt_o = gt_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmp_share_arb.sv
// Randomized scoreboard bench for cmp_share_arb: per-requester expected-result queues
// filled at issue time, and a cycle-level round-robin reference checked by a negedge monitor.
module tb_cmp_share_arb;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req   = '0;
    logic [NREQ*W-1:0] a_in  = '0;
    logic [NREQ*W-1:0] b_in  = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              res_eq, res_lt, res_gt, busy;

    int n_cmp = 0;
    int n_err = 0;

    cmp_share_arb #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .req_i    (req),
        .a_in_i   (a_in),
        .b_in_i   (b_in),
        .gnt_o    (gnt),
        .ack_o    (ack),
        .res_eq_o (res_eq),
        .res_lt_o (res_lt),
        .res_gt_o (res_gt),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } job_t;

    job_t       jq    [NREQ][$];
    logic [2:0] exp_q [NREQ][$];
    bit         active    [NREQ];
    bit         drop_next [NREQ];
    bit         scramble_en = 1'b1;
    bit         drop_en     = 1'b0;

    // {eq, lt, gt} from plain integer comparison of the operand values
    function automatic logic [2:0] ref_cmp(logic [W-1:0] a, logic [W-1:0] b);
        int sa, sb;
`ifdef CMP_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        return {sa == sb, sa < sb, sa > sb};
    endfunction

    function automatic int rr_pick(logic [NREQ-1:0] cand, int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (cand[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    int              m_ptr      = 0;
    logic [NREQ-1:0] m_prev_gnt = '0;
    logic [NREQ-1:0] m_prev_ack = '0;
    logic [NREQ-1:0] m_prev_req = '0;
    logic [2:0]      m_res      = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] cand;
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_ack;
        if (!rst_n) begin
            check("reset_outputs", 32'({gnt, ack, res_eq, res_lt, res_gt, busy}), 32'(0));
            m_ptr      = 0;
            m_prev_gnt = '0;
            m_prev_ack = '0;
            m_prev_req = '0;
            m_res      = '0;
            for (int i = 0; i < NREQ; i++) exp_q[i].delete();
        end else begin
            cand  = m_prev_req & ~m_prev_ack;
            e_gnt = '0;
            if (m_prev_gnt == '0 && cand != '0) e_gnt[rr_pick(cand, m_ptr)] = 1'b1;
            e_ack = m_prev_gnt;
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("ack", 32'(ack), 32'(e_ack));
            check("busy", 32'(busy), 32'((e_gnt != '0) || (e_ack != '0)));
            for (int i = 0; i < NREQ; i++) begin
                if (e_ack[i]) begin
                    n_cmp++;
                    if (exp_q[i].size() == 0) begin
                        n_err++;
                        $display("FAIL ack_job: requester %0d acked, expected an outstanding job, found none", i);
                    end else begin
                        m_res = exp_q[i].pop_front();
                    end
                    m_ptr = (i + 1) % NREQ;
                end
            end
            check("result_eq_lt_gt", 32'({res_eq, res_lt, res_gt}), 32'(m_res));
            m_prev_gnt = e_gnt;
            m_prev_ack = e_ack;
            m_prev_req = req;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(int i, logic [W-1:0] a, logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
        req[i]         = 1'b1;
        active[i]      = 1'b1;
        drop_next[i]   = 1'b0;
        exp_q[i].push_back(ref_cmp(a, b));
    endtask

    task automatic push_job(int i, logic [W-1:0] a, logic [W-1:0] b);
        job_t j;
        j.a = a;
        j.b = b;
        jq[i].push_back(j);
    endtask

    task automatic step();
        job_t j;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (drop_next[i]) begin
                req[i]       = 1'b0;
                drop_next[i] = 1'b0;
            end
            if (ack[i] && active[i]) begin
                active[i] = 1'b0;
                if (jq[i].size() != 0) begin
                    j = jq[i].pop_front();
                    issue(i, j.a, j.b);
                end else begin
                    drop_next[i] = 1'b1;
                end
            end else if (gnt[i] && active[i]) begin
                if (scramble_en) begin
                    a_in[i*W +: W] = W'($urandom);
                    b_in[i*W +: W] = W'($urandom);
                end
                if (drop_en && $urandom_range(3) == 0) req[i] = 1'b0;
            end else if (!active[i] && !drop_next[i] && jq[i].size() != 0) begin
                j = jq[i].pop_front();
                issue(i, j.a, j.b);
            end
        end
    endtask

    function automatic bit quiet();
        bit q = (busy === 1'b0);
        for (int i = 0; i < NREQ; i++) begin
            if (active[i] || drop_next[i] || jq[i].size() != 0) q = 1'b0;
        end
        return q;
    endfunction

    task automatic wait_quiet(string name, int maxc);
        int c = 0;
        while (c < maxc && !quiet()) begin
            step();
            c++;
        end
        n_cmp++;
        if (!quiet()) begin
            n_err++;
            $display("FAIL timeout_%s: still busy after %0d cycles, required idle", name, maxc);
        end
    endtask

    task automatic wait_gnt(int i, int maxc);
        int c = 0;
        while (c < maxc && !gnt[i]) begin
            step();
            c++;
        end
        n_cmp++;
        if (!gnt[i]) begin
            n_err++;
            $display("FAIL timeout_gnt%0d: no grant within %0d cycles", i, maxc);
        end
    endtask

    task automatic reset_mid_op();
        rst_n = 1'b0;
        #1;
        check("reset_immediate", 32'({gnt, ack, res_eq, res_lt, res_gt, busy}), 32'(0));
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            active[i]    = 1'b0;
            drop_next[i] = 1'b0;
            jq[i].delete();
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(5))
            0:       return '0;
            1:       return '1;
            2:       return 8'h80;
            3:       return 8'h7F;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // all requesters at once, requester 0 twice: order 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) issue(i, W'(i), 8'd2);
        push_job(0, 8'd0, 8'd2);
        wait_quiet("all_req", 100);

        issue(0, 8'd5, 8'd5);
        wait_quiet("single", 20);

        issue(0, 8'h00, 8'hFF);
        wait_quiet("bound0", 20);
        issue(1, 8'hFF, 8'h00);
        wait_quiet("bound1", 20);
        issue(2, 8'hFF, 8'hFF);
        wait_quiet("bound2", 20);

        // operands change after the grant edge; result must use the captured pair
        scramble_en = 1'b0;
        issue(1, 8'd10, 8'd20);
        wait_gnt(1, 20);
        a_in[1*W +: W] = 8'd30;
        wait_quiet("opchange", 20);
        scramble_en = 1'b1;

        // requester 2 re-requests through its ack while 3 waits: order 2,3,2
        issue(2, 8'd40, 8'd41);
        push_job(2, 8'd42, 8'd41);
        step();
        issue(3, 8'd7, 8'd7);
        wait_quiet("mask", 40);

        issue(1, 8'd7, 8'd9);
        wait_gnt(1, 20);
        reset_mid_op();
        issue(1, 8'd3, 8'd1);
        wait_quiet("post_reset", 20);

        // leave the pointer at 3, reset mid-grant, then requesters 0 and 3 race: 0 must win
        issue(2, 8'd1, 8'd1);
        wait_quiet("ptr_setup", 20);
        issue(1, 8'd9, 8'd8);
        wait_gnt(1, 20);
        reset_mid_op();
        issue(0, 8'd11, 8'd12);
        issue(3, 8'd13, 8'd12);
        wait_quiet("ptr_reset", 30);

        drop_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!active[i] && !drop_next[i] && jq[i].size() == 0 && $urandom_range(3) == 0) begin
                    ra = rand_op();
                    rb = ($urandom_range(3) == 0) ? ra : rand_op();
                    push_job(i, ra, rb);
                end
            end
        end
        wait_quiet("random", 200);
        repeat (2) step();

        for (int i = 0; i < NREQ; i++) check("jobs_drained", 32'(exp_q[i].size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmp_share_arb.md
Name: cmp_share_arb

Overview:
- Round-robin scheduler that shares one registered 8-bit magnitude comparator (eq/lt/gt) among NREQ requesters.
- Each requester presents an operand pair and holds a request. The block grants one requester, latches its operands, compares them, and returns the result with a one-cycle ack pulse.
- Sits between multiple control FSMs and the single comparator datapath, so the compare logic is not replicated.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; held high until the matching ack.
- a_in  input  NREQ*WIDTH  flattened A operands; requester i at bits [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  flattened B operands, same packing.
- gnt  output  NREQ  one-hot grant, registered.
- ack  output  NREQ  one-hot, one-cycle pulse; result valid in the same cycle.
- res_eq  output  1  A == B for the acked request.
- res_lt  output  1  A < B.
- res_gt  output  1  A > B.
- busy  output  1  high in GRANT and RESULT states.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_n low immediately clears gnt, ack, res_eq, res_lt, res_gt and busy to 0.
  - FSM goes to IDLE; round-robin pointer goes to 0.
- FSM states: IDLE, GRANT, RESULT.
- IDLE:
  - If req != 0, pick the winner by round-robin starting at the pointer.
  - Next cycle: gnt = one-hot winner, operands latched, state = GRANT.
  - If req == 0, stay in IDLE.
- GRANT:
  - Compute the comparison on the latched operands.
  - Next cycle: ack[winner] = 1; res_* registered; gnt cleared; state = RESULT; pointer = winner+1 mod NREQ.
- RESULT:
  - ack is high this cycle only.
  - Arbitrate over req & ~ack, masking the just-acked requester, whose req may still be high.
  - If any request remains, go to GRANT with the new gnt and operands latched; otherwise go to IDLE.
- Latency and throughput:
  - req rising in IDLE at cycle 0: gnt at cycle 1, ack plus result at cycle 2.
  - Back-to-back: one result every 2 cycles.
- Result flags:
  - Exactly one of res_eq/res_lt/res_gt is high after the first ack.
  - All three hold their value until the next ack. All are 0 before the first ack.
- Operand capture: operands are sampled only on the grant edge. Later changes to a_in/b_in do not affect an in-flight result.
- Handshake rules:
  - A requester deasserts req in the cycle after its ack, or keeps it high to request again.
  - If req of the granted requester drops while in GRANT, the compare still completes and ack is still issued.
- Fairness: with all requests held continuously, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ grants.
- Reset mid-operation: the in-flight compare is discarded and no ack is issued.
- Widths: unsigned compare over full WIDTH bits. No wrap or overflow concerns.

Optional Feature:
- Macro: CMP_SIGNED_EN.
- Defined: operands are compared as two's-complement signed values, e.g. 8'hFF (-1) < 8'h01.
- Undefined: unsigned compare, e.g. 8'hFF > 8'h01.
- Grant, ack, state machine and timing are identical in both builds.

Test Plan:
- Single request: req=4'b0001, a0=8'd5, b0=8'd5, held → gnt=0001 at cycle 1; ack=0001 at cycle 2 with res_eq=1, res_lt=0, res_gt=0; busy=1 over cycles 1-2, then 0.
- All requesting: req=1111 held; ai=i, bi=2 → ack order 0,1,2,3,0 with acks 2 cycles apart; results lt, lt, eq, gt, lt.
- Operand change after grant: grant requester 1 with a1=10, b1=20; change a1 to 30 in the GRANT cycle → ack with res_lt=1 (old operands used).
- Reset mid-operation: pull rst_n low during GRANT → all outputs are 0 immediately; after release with req=0010, gnt=0010 one cycle later and pointer restarts from 0.
- Boundaries: a=8'h00, b=8'hFF → res_lt=1; a=8'hFF, b=8'h00 → res_gt=1; a=b=8'hFF → res_eq=1.
  - With CMP_SIGNED_EN defined: the first two results swap (res_gt=1, then res_lt=1).
- Masking: requester 2 keeps req high through its ack while requester 3 is requesting → requester 3 is granted next (not requester 2 again), then requester 2.
